// File: rtl/dma_axi_mem_slave.sv
// ---------------------------------------------------------------------------
// dma_axi_mem_slave
//   AXI4 full-slave memory responder that terminates the DMA master port.
//   Read and write bursts are served from an internal word array by two
//   independent channel FSMs. Out-of-range beats, WRAP/reserved bursts and
//   oversize transfers are answered with SLVERR.
//
//   Ports
//     clk         : clock
//     rst_n       : asynchronous active-low reset
//     axi_mosi_i  : packed s_axi_mosi_t (AW/W/AR channels, bready, rready)
//     axi_miso_o  : packed s_axi_miso_t (awready, wready, B channel,
//                   arready, R channel)
//
//   Configuration
//     AXI_DATA_WIDTH : data width in bits (32 or 64), defaults to 32
//     AXI_MEM_BP_EN  : when defined, an LFSR injects random backpressure
// ---------------------------------------------------------------------------
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

package dma_axi_mem_slave_pkg;
  localparam int AXI_DW  = `AXI_DATA_WIDTH;
  localparam int AXI_SW  = AXI_DW / 8;
  localparam int AXI_IDW = 4;
  localparam int AXI_AW  = 64;

  typedef struct packed {
    logic [AXI_IDW-1:0] awid;
    logic [AXI_AW-1:0]  awaddr;
    logic [7:0]         awlen;
    logic [2:0]         awsize;
    logic [1:0]         awburst;
    logic               awvalid;
    logic [AXI_DW-1:0]  wdata;
    logic [AXI_SW-1:0]  wstrb;
    logic               wlast;
    logic               wvalid;
    logic               bready;
    logic [AXI_IDW-1:0] arid;
    logic [AXI_AW-1:0]  araddr;
    logic [7:0]         arlen;
    logic [2:0]         arsize;
    logic [1:0]         arburst;
    logic               arvalid;
    logic               rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic               awready;
    logic               wready;
    logic               bvalid;
    logic [AXI_IDW-1:0] bid;
    logic [1:0]         bresp;
    logic               arready;
    logic               rvalid;
    logic [AXI_IDW-1:0] rid;
    logic [AXI_DW-1:0]  rdata;
    logic [1:0]         rresp;
    logic               rlast;
  } s_axi_miso_t;
endpackage

module dma_axi_mem_slave
  import dma_axi_mem_slave_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [$bits(s_axi_mosi_t)-1:0]   axi_mosi_i,
  output logic [$bits(s_axi_miso_t)-1:0]   axi_miso_o
);

  localparam int BYTE_SHIFT = $clog2(AXI_SW);
  localparam int IDX_W      = $clog2(MEM_WORDS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  // The INIT states keep every ready low until the first edge after reset.
  typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_RESP} wState_e;
  typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} rState_e;

  s_axi_mosi_t mosi;
  s_axi_miso_t miso;
  assign mosi       = axi_mosi_i;
  assign axi_miso_o = miso;

  logic [AXI_DW-1:0] mem [MEM_WORDS];

  // A beat is illegal when it falls outside the mapped window, uses a WRAP
  // or reserved burst, or asks for more bytes than one word holds.
  function automatic logic beatErr(input logic [63:0] addr,
                                   input logic [2:0]  size,
                                   input logic [1:0]  burst);
    logic [63:0] off;
    off = addr - BASE_ADDR;
    return (addr < BASE_ADDR) || ((off >> BYTE_SHIFT) >= 64'(MEM_WORDS)) ||
           burst[1] || (size > 3'(BYTE_SHIFT));
  endfunction

  function automatic logic [IDX_W-1:0] wordIdx(input logic [63:0] addr);
    logic [63:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> BYTE_SHIFT);
  endfunction

  function automatic logic [63:0] nextAddr(input logic [63:0] addr,
                                           input logic [2:0]  size,
                                           input logic [1:0]  burst);
    return (burst == BURST_FIXED) ? addr : addr + (64'd1 << size);
  endfunction

  // Backpressure source: while stall is high no new handshake is offered
  // and no new valid is raised; valids already shown are held.
  logic stall;
`ifdef AXI_MEM_BP_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall = lfsr_q[0];
`else
  logic unusedSeed;
  assign unusedSeed = ^LFSR_SEED;
  assign stall      = 1'b0;
`endif

  // ---------------------------------------------------------------- write
  wState_e            wState_q, wState_d;
  logic [AXI_IDW-1:0] awId_q;
  logic [63:0]        wAddr_q;
  logic [7:0]         awLen_q;
  logic [2:0]         awSize_q;
  logic [1:0]         awBurst_q;
  logic [7:0]         wBeat_q;
  logic               wErr_q;
  logic               bShown_q;

  logic awReady, wReady, bValid, awHs, wHs, bHs, wBeatErr, wLastBeat;

  assign wBeatErr  = beatErr(wAddr_q, awSize_q, awBurst_q);
  assign wLastBeat = mosi.wlast || (wBeat_q == awLen_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wState_q <= W_INIT;
    else        wState_q <= wState_d;
  end

  // The beat count ends the burst even if wlast never arrives; an early
  // wlast ends it as well.
  always_comb begin
    wState_d = wState_q;
    awReady  = 1'b0;
    wReady   = 1'b0;
    bValid   = 1'b0;
    case (wState_q)
      W_INIT: wState_d = W_IDLE;
      W_IDLE: begin
        awReady = !stall;
        if (awReady && mosi.awvalid) wState_d = W_DATA;
      end
      W_DATA: begin
        wReady = !stall;
        if (wReady && mosi.wvalid && wLastBeat) wState_d = W_RESP;
      end
      W_RESP: begin
        bValid = bShown_q || !stall;
        if (bValid && mosi.bready) wState_d = W_IDLE;
      end
      default: wState_d = W_INIT;
    endcase
  end

  assign awHs = awReady && mosi.awvalid;
  assign wHs  = wReady && mosi.wvalid;
  assign bHs  = bValid && mosi.bready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awId_q    <= '0;
      wAddr_q   <= '0;
      awLen_q   <= '0;
      awSize_q  <= '0;
      awBurst_q <= '0;
      wBeat_q   <= '0;
      wErr_q    <= 1'b0;
      bShown_q  <= 1'b0;
    end else begin
      bShown_q <= bValid && !bHs;
      if (awHs) begin
        awId_q    <= mosi.awid;
        wAddr_q   <= mosi.awaddr;
        awLen_q   <= mosi.awlen;
        awSize_q  <= mosi.awsize;
        awBurst_q <= mosi.awburst;
        wBeat_q   <= '0;
        wErr_q    <= 1'b0;
      end else if (wHs) begin
        wErr_q  <= wErr_q | wBeatErr;
        wAddr_q <= nextAddr(wAddr_q, awSize_q, awBurst_q);
        wBeat_q <= wBeat_q + 8'd1;
      end
    end
  end

  // Array storage has no reset so that a mid-burst reset keeps the words
  // already written.
  always_ff @(posedge clk) begin
    if (wHs && !wBeatErr) begin
      for (int i = 0; i < AXI_SW; i++) begin
        if (mosi.wstrb[i]) mem[wordIdx(wAddr_q)][8*i +: 8] <= mosi.wdata[8*i +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  rState_e            rState_q, rState_d;
  logic [AXI_IDW-1:0] arId_q;
  logic [63:0]        rAddr_q;
  logic [7:0]         arLen_q;
  logic [2:0]         arSize_q;
  logic [1:0]         arBurst_q;
  logic [7:0]         rBeat_q;
  logic [AXI_DW-1:0]  rdata_q;
  logic [1:0]         rresp_q;
  logic               rShown_q;

  logic              arReady, rValid, arHs, rHs, rLastBeat, loadErr;
  logic [63:0]       loadAddr;
  logic [2:0]        loadSize;
  logic [1:0]        loadBurst;
  logic [AXI_DW-1:0] loadData;

  assign rLastBeat = (rBeat_q == arLen_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rState_q <= R_INIT;
    else        rState_q <= rState_d;
  end

  always_comb begin
    rState_d = rState_q;
    arReady  = 1'b0;
    rValid   = 1'b0;
    case (rState_q)
      R_INIT: rState_d = R_IDLE;
      R_IDLE: begin
        arReady = !stall;
        if (arReady && mosi.arvalid) rState_d = R_DATA;
      end
      R_DATA: begin
        rValid = rShown_q || !stall;
        if (rValid && mosi.rready && rLastBeat) rState_d = R_IDLE;
      end
      default: rState_d = R_INIT;
    endcase
  end

  assign arHs = arReady && mosi.arvalid;
  assign rHs  = rValid && mosi.rready;

  // Read data is captured into a register when a beat is issued, so it
  // stays stable under backpressure and a same-edge write is not seen.
  always_comb begin
    loadAddr  = nextAddr(rAddr_q, arSize_q, arBurst_q);
    loadSize  = arSize_q;
    loadBurst = arBurst_q;
    if (arHs) begin
      loadAddr  = mosi.araddr;
      loadSize  = mosi.arsize;
      loadBurst = mosi.arburst;
    end
    loadErr  = beatErr(loadAddr, loadSize, loadBurst);
    loadData = mem[wordIdx(loadAddr)];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arId_q    <= '0;
      rAddr_q   <= '0;
      arLen_q   <= '0;
      arSize_q  <= '0;
      arBurst_q <= '0;
      rBeat_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rShown_q  <= 1'b0;
    end else begin
      rShown_q <= rValid && !rHs;
      if (arHs) begin
        arId_q    <= mosi.arid;
        rAddr_q   <= mosi.araddr;
        arLen_q   <= mosi.arlen;
        arSize_q  <= mosi.arsize;
        arBurst_q <= mosi.arburst;
        rBeat_q   <= '0;
        rdata_q   <= loadErr ? '0 : loadData;
        rresp_q   <= loadErr ? RESP_SLVERR : RESP_OKAY;
      end else if (rHs && !rLastBeat) begin
        rAddr_q <= loadAddr;
        rBeat_q <= rBeat_q + 8'd1;
        rdata_q <= loadErr ? '0 : loadData;
        rresp_q <= loadErr ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // -------------------------------------------------------------- outputs
  always_comb begin
    miso         = '0;
    miso.awready = awReady;
    miso.wready  = wReady;
    miso.bvalid  = bValid;
    miso.bid     = awId_q;
    miso.bresp   = wErr_q ? RESP_SLVERR : RESP_OKAY;
    miso.arready = arReady;
    miso.rvalid  = rValid;
    miso.rid     = arId_q;
    miso.rdata   = rdata_q;
    miso.rresp   = rresp_q;
    miso.rlast   = rValid && rLastBeat;
  end

endmodule

// File: tb/tb_dma_axi_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_dma_axi_mem_slave
//   Directed bench for dma_axi_mem_slave in the default 32-bit build with a
//   256-word array mapped at byte address 0x1000. Inputs change on the
//   falling edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_dma_axi_mem_slave;
  import dma_axi_mem_slave_pkg::*;

  localparam logic [63:0] BASE  = 64'h1000;
  localparam logic [1:0]  FIXED = 2'b00;
  localparam logic [1:0]  INCR  = 2'b01;
  localparam logic [1:0]  WRAP  = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  s_axi_mosi_t m;
  logic [$bits(s_axi_miso_t)-1:0] misoVec;
  s_axi_miso_t s;
  assign s = misoVec;

  int testCount = 0;
  int failCount = 0;

  logic [31:0] wrData [16];
  logic [31:0] rdData [16];
  logic [1:0]  rdResp [16];
  logic        rdLast [16];
  logic [3:0]  rdIdSeen;
  logic        firstValid;
  logic [1:0]  bRespSeen;
  logic [3:0]  bIdSeen;

  dma_axi_mem_slave #(.MEM_WORDS(256), .BASE_ADDR(BASE), .LFSR_SEED(16'hACE1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .axi_mosi_i (m),
    .axi_miso_o (misoVec)
  );

  // Runaway guard in case a handshake never completes.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    m = '0;
  endtask

  task automatic issueAw(input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id);
    m.awaddr = addr; m.awlen = len; m.awsize = size; m.awburst = burst; m.awid = id;
    m.awvalid = 1'b1;
    for (int i = 0; i < 50 && !s.awready; i++) @(negedge clk);
    checkOutput("awAccept", 64'(s.awready), 64'h1);
    @(negedge clk);
    m.awvalid = 1'b0;
  endtask

  task automatic collectResp();
    m.bready = 1'b1;
    for (int i = 0; i < 50 && !s.bvalid; i++) @(negedge clk);
    checkOutput("bValid", 64'(s.bvalid), 64'h1);
    bRespSeen = s.bresp;
    bIdSeen   = s.bid;
    @(negedge clk);
    m.bready = 1'b0;
  endtask

  task automatic writeBurst(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input logic [3:0] strb,
                            input bit waitResp);
    issueAw(addr, len, size, burst, id);
    for (int b = 0; b <= int'(len); b++) begin
      m.wdata = wrData[b]; m.wstrb = strb; m.wlast = (b == int'(len)); m.wvalid = 1'b1;
      for (int i = 0; i < 50 && !s.wready; i++) @(negedge clk);
      checkOutput("wAccept", 64'(s.wready), 64'h1);
      @(negedge clk);
    end
    m.wvalid = 1'b0; m.wlast = 1'b0;
    if (waitResp) collectResp();
  endtask

  task automatic issueAr(input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id);
    m.araddr = addr; m.arlen = len; m.arsize = size; m.arburst = burst; m.arid = id;
    m.arvalid = 1'b1;
    for (int i = 0; i < 50 && !s.arready; i++) @(negedge clk);
    checkOutput("arAccept", 64'(s.arready), 64'h1);
    @(negedge clk);
    m.arvalid  = 1'b0;
    firstValid = s.rvalid;
  endtask

  task automatic readBurst(input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id);
    issueAr(addr, len, size, burst, id);
    m.rready = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      for (int i = 0; i < 50 && !s.rvalid; i++) @(negedge clk);
      checkOutput("rValid", 64'(s.rvalid), 64'h1);
      rdData[b] = s.rdata; rdResp[b] = s.rresp; rdLast[b] = s.rlast; rdIdSeen = s.rid;
      @(negedge clk);
    end
    m.rready = 1'b0;
  endtask

  initial begin
    applyStimulus();

    // Reset: every output low, readies rise one edge after release.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetAllZero", 64'(|misoVec), 64'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("awreadyBeforeEdge", 64'(s.awready), 64'h0);
    checkOutput("arreadyBeforeEdge", 64'(s.arready), 64'h0);
    @(negedge clk);
    checkOutput("awreadyAfterEdge", 64'(s.awready), 64'h1);
    checkOutput("arreadyAfterEdge", 64'(s.arready), 64'h1);

    // INCR write of 0..7 then read back.
    for (int b = 0; b < 8; b++) wrData[b] = 32'(b);
    writeBurst(BASE + 64'h100, 8'd7, 3'd2, INCR, 4'd3, 4'hF, 1'b1);
    checkOutput("incrBresp", 64'(bRespSeen), 64'h0);
    checkOutput("incrBid", 64'(bIdSeen), 64'h3);
    readBurst(BASE + 64'h100, 8'd7, 3'd2, INCR, 4'd5);
    checkOutput("firstRvalidLatency", 64'(firstValid), 64'h1);
    checkOutput("incrRid", 64'(rdIdSeen), 64'h5);
    for (int b = 0; b < 8; b++) begin
      checkOutput("incrRdata", 64'(rdData[b]), 64'(b));
      checkOutput("incrRresp", 64'(rdResp[b]), 64'h0);
      checkOutput("incrRlast", 64'(rdLast[b]), (b == 7) ? 64'h1 : 64'h0);
    end

    // Byte strobes merge into the existing word.
    wrData[0] = 32'hFFFF_FFFF;
    writeBurst(BASE + 64'h200, 8'd0, 3'd2, INCR, 4'd1, 4'hF, 1'b1);
    wrData[0] = 32'h1234_5678;
    writeBurst(BASE + 64'h200, 8'd0, 3'd2, INCR, 4'd1, 4'b0101, 1'b1);
    readBurst(BASE + 64'h200, 8'd0, 3'd2, INCR, 4'd1);
    checkOutput("strobeMerge", 64'(rdData[0]), 64'hFF34_FF78);

    // Burst running off the end of the array.
    wrData[0] = 32'h5A5A_5A5A;
    writeBurst(BASE, 8'd0, 3'd2, INCR, 4'd1, 4'hF, 1'b1);
    wrData[0] = 32'hA0; wrData[1] = 32'hA1; wrData[2] = 32'hA2; wrData[3] = 32'hA3;
    writeBurst(BASE + 64'h3FC, 8'd3, 3'd2, INCR, 4'd2, 4'hF, 1'b1);
    checkOutput("oorBresp", 64'(bRespSeen), 64'h2);
    readBurst(BASE + 64'h3FC, 8'd3, 3'd2, INCR, 4'd2);
    checkOutput("oorRdata0", 64'(rdData[0]), 64'hA0);
    checkOutput("oorRresp0", 64'(rdResp[0]), 64'h0);
    for (int b = 1; b < 4; b++) begin
      checkOutput("oorRdataErr", 64'(rdData[b]), 64'h0);
      checkOutput("oorRrespErr", 64'(rdResp[b]), 64'h2);
    end
    readBurst(BASE, 8'd0, 3'd2, INCR, 4'd2);
    checkOutput("oorWord0Intact", 64'(rdData[0]), 64'h5A5A_5A5A);

    // FIXED burst lands every beat on one word.
    wrData[0] = 32'h3333_3333;
    writeBurst(BASE + 64'h304, 8'd0, 3'd2, INCR, 4'd1, 4'hF, 1'b1);
    wrData[0] = 32'd1; wrData[1] = 32'd2; wrData[2] = 32'd3; wrData[3] = 32'd4;
    writeBurst(BASE + 64'h300, 8'd3, 3'd2, FIXED, 4'd4, 4'hF, 1'b1);
    checkOutput("fixedBresp", 64'(bRespSeen), 64'h0);
    readBurst(BASE + 64'h300, 8'd1, 3'd2, INCR, 4'd4);
    checkOutput("fixedWord", 64'(rdData[0]), 64'h4);
    checkOutput("fixedNeighbour", 64'(rdData[1]), 64'h3333_3333);

    // WRAP and oversize bursts are rejected without touching memory.
    for (int b = 0; b < 4; b++) wrData[b] = 32'hDEAD_0000 | 32'(b);
    writeBurst(BASE + 64'h100, 8'd3, 3'd2, WRAP, 4'd6, 4'hF, 1'b1);
    checkOutput("wrapBresp", 64'(bRespSeen), 64'h2);
    wrData[0] = 32'hBEEF_BEEF;
    writeBurst(BASE + 64'h100, 8'd0, 3'd3, INCR, 4'd6, 4'hF, 1'b1);
    checkOutput("sizeBresp", 64'(bRespSeen), 64'h2);
    readBurst(BASE + 64'h100, 8'd3, 3'd2, INCR, 4'd6);
    for (int b = 0; b < 4; b++) checkOutput("wrapMemIntact", 64'(rdData[b]), 64'(b));
    readBurst(BASE + 64'h100, 8'd1, 3'd2, WRAP, 4'd6);
    checkOutput("wrapRresp", 64'(rdResp[0]), 64'h2);
    checkOutput("wrapRdata", 64'(rdData[1]), 64'h0);

    // bready held low: B holds and no new AW is accepted.
    wrData[0] = 32'h77;
    writeBurst(BASE + 64'h208, 8'd0, 3'd2, INCR, 4'd9, 4'hF, 1'b0);
    for (int i = 0; i < 50 && !s.bvalid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bHoldValid", 64'(s.bvalid), 64'h1);
      checkOutput("bHoldId", 64'(s.bid), 64'h9);
      checkOutput("bHoldAwready", 64'(s.awready), 64'h0);
      @(negedge clk);
    end
    collectResp();
    checkOutput("bHoldResp", 64'(bRespSeen), 64'h0);
    checkOutput("awreadyAfterB", 64'(s.awready), 64'h1);

    // rready toggling: each beat holds until it is taken.
    issueAr(BASE + 64'h100, 8'd3, 3'd2, INCR, 4'd2);
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 50 && !s.rvalid; i++) @(negedge clk);
      checkOutput("toggleRdata", 64'(s.rdata), 64'(b));
      @(negedge clk);
      checkOutput("toggleRvalidHeld", 64'(s.rvalid), 64'h1);
      checkOutput("toggleRdataStable", 64'(s.rdata), 64'(b));
      checkOutput("toggleRlastStable", 64'(s.rlast), (b == 3) ? 64'h1 : 64'h0);
      m.rready = 1'b1;
      @(negedge clk);
      m.rready = 1'b0;
    end
    checkOutput("toggleDone", 64'(s.rvalid), 64'h0);

    // Same-edge write and read of one word returns the old data.
    issueAw(BASE + 64'h200, 8'd0, 3'd2, INCR, 4'd7);
    m.wdata = 32'hCAFE_F00D; m.wstrb = 4'hF; m.wlast = 1'b1; m.wvalid = 1'b1;
    m.araddr = BASE + 64'h200; m.arlen = 8'd0; m.arsize = 3'd2; m.arburst = INCR;
    m.arid = 4'd7; m.arvalid = 1'b1;
    checkOutput("collideWready", 64'(s.wready), 64'h1);
    checkOutput("collideArready", 64'(s.arready), 64'h1);
    @(negedge clk);
    m.wvalid = 1'b0; m.wlast = 1'b0; m.arvalid = 1'b0;
    checkOutput("collideRvalid", 64'(s.rvalid), 64'h1);
    checkOutput("collideOldData", 64'(s.rdata), 64'hFF34_FF78);
    m.rready = 1'b1;
    collectResp();
    m.rready = 1'b0;
    readBurst(BASE + 64'h200, 8'd0, 3'd2, INCR, 4'd7);
    checkOutput("collideNewData", 64'(rdData[0]), 64'hCAFE_F00D);

    // Reset in the middle of a read burst.
    issueAr(BASE + 64'h100, 8'd7, 3'd2, INCR, 4'd6);
    m.rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midReadBeat2", 64'(s.rdata), 64'h2);
    rst_n = 1'b0;
    #1;
    checkOutput("midResetRvalid", 64'(s.rvalid), 64'h0);
    checkOutput("midResetAllZero", 64'(|misoVec), 64'h0);
    m.rready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midReleaseArready0", 64'(s.arready), 64'h0);
    @(negedge clk);
    checkOutput("midReleaseArready1", 64'(s.arready), 64'h1);
    readBurst(BASE + 64'h100, 8'd7, 3'd2, INCR, 4'd8);
    for (int b = 0; b < 8; b++) begin
      checkOutput("postResetRdata", 64'(rdData[b]), 64'(b));
      checkOutput("postResetRlast", 64'(rdLast[b]), (b == 7) ? 64'h1 : 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
